// File: rtl/inv_key_schedule.sv
// inv_key_schedule: iterative AES-128 reverse key schedule.
// Loads the round-10 key and walks back to round 0, emitting one round key
// every two cycles (one cycle for the registered SubWord, one to update).
//
// Ports:
//   clk       - rising-edge clock
//   rst_n     - asynchronous active-low reset
//   start     - begin expansion (sampled only in IDLE)
//   key_in    - round-10 key, word 0 in [127:96]
//   round_key - current round key, same word order as key_in
//   round_idx - round number of round_key (10..0)
//   rk_valid  - one-cycle pulse when round_key/round_idx are new
//   done      - one-cycle pulse together with the round-0 rk_valid
//   busy      - high from the cycle after start up to and including done

// sub_word: registered 4-byte AES S-box lookup, one cycle of latency.
//   clk      - clock
//   word_in  - 32-bit input word
//   word_out - S-box of each byte, registered
module sub_word (
  input  logic        clk,
  input  logic [31:0] word_in,
  output logic [31:0] word_out
);

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[(255 - int'(x)) * 8 +: 8];
  endfunction

  logic [31:0] word_d, word_q;

  always_comb begin
    word_d = {sbox(word_in[31:24]), sbox(word_in[23:16]),
              sbox(word_in[15:8]),  sbox(word_in[7:0])};
  end

  // Capture is don't-care out of reset, so no reset on this register.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign word_out = word_q;

endmodule

module inv_key_schedule (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         rk_valid,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, SUB, UPD} state_t;

  state_t       state_d, state_q;
  logic [127:0] key_d, key_q;
  logic [3:0]   round_d, round_q;
  logic         rk_valid_d, rk_valid_q;
  logic         done_d, done_q;
  logic         busy_d, busy_q;

  logic [31:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic [31:0]  sw_in, sw_out;

  // Rcon for the current round r (key r -> r-1 uses Rcon[r]).
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // key_q is stable during SUB, so the SubWord result captured at the end
  // of SUB matches the b1..b3 computed from key_q in UPD.
  sub_word u_sub_word (
    .clk      (clk),
    .word_in  (sw_in),
    .word_out (sw_out)
  );

  always_comb begin
    {a0, a1, a2, a3} = key_q;
    b3    = a3 ^ a2;
    b2    = a2 ^ a1;
    b1    = a1 ^ a0;
    sw_in = {b3[23:0], b3[31:24]};
    b0    = a0 ^ sw_out ^ {rcon(round_q), 24'h0};

    state_d    = state_q;
    key_d      = key_q;
    round_d    = round_q;
    rk_valid_d = 1'b0;
    done_d     = 1'b0;
    busy_d     = busy_q;

    case (state_q)
      IDLE: begin
        // Holding key/round here keeps round 0 visible after completion.
        busy_d = 1'b0;
        if (start) begin
          key_d      = key_in;
          round_d    = 4'd10;
          rk_valid_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = SUB;
        end
      end
      SUB: begin
        state_d = UPD;
      end
      UPD: begin
        key_d      = {b0, b1, b2, b3};
        round_d    = round_q - 4'd1;
        rk_valid_d = 1'b1;
        if (round_q == 4'd1) begin
          // busy stays high through the done cycle; IDLE drops it next.
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = SUB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      key_q      <= '0;
      round_q    <= '0;
      rk_valid_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      round_q    <= round_d;
      rk_valid_q <= rk_valid_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign round_key = key_q;
  assign round_idx = round_q;
  assign rk_valid  = rk_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_inv_key_schedule.sv
// Directed bench for inv_key_schedule: FIPS-197 round keys, a zero-key run,
// ignored starts, mid-run reset, back-to-back runs and long idle.
module tb_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_in = '0;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         rk_valid, done, busy;

  int checks = 0;
  int failures = 0;

  logic [127:0] fips [0:10];
  localparam logic [127:0] ZERO_R10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
  localparam logic [127:0] ZERO_R1  = 128'h62636363626363636263636362636363;

  inv_key_schedule dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .key_in    (key_in),
    .round_key (round_key),
    .round_idx (round_idx),
    .rk_valid  (rk_valid),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; the next rising edge samples them.
  task automatic kick(input logic [127:0] k);
    key_in = k;
    start  = 1'b1;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({rk_valid, done, busy} !== 3'b000 || round_key !== '0 || round_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_state: got v=%b d=%b b=%b idx=%0d key=%h, want all zero",
               rk_valid, done, busy, round_idx, round_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_idle();
    for (int c = 0; c < 50; c++) begin
      checks++;
      if ({rk_valid, done, busy} !== 3'b000 || round_key !== '0) begin
        failures++;
        $display("FAIL idle cyc %0d: got v=%b d=%b b=%b key=%h, want zeros",
                 c, rk_valid, done, busy, round_key);
      end
      @(negedge clk);
    end
  endtask

  // Full cycle-exact check: after E(k) round 10-k/2 is shown, rk_valid on even k.
  task automatic test_fips();
    kick(fips[10]);
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if (rk_valid !== (k % 2 == 0) || done !== (k == 20) || busy !== 1'b1 ||
          round_idx !== 4'(10 - k / 2) || round_key !== fips[10 - k / 2]) begin
        failures++;
        $display("FAIL fips cyc %0d: got v=%b d=%b b=%b idx=%0d key=%h, want v=%b d=%b b=1 idx=%0d key=%h",
                 k, rk_valid, done, busy, round_idx, round_key,
                 (k % 2 == 0), (k == 20), 10 - k / 2, fips[10 - k / 2]);
      end
      @(negedge clk);
    end
    checks++;
    if ({rk_valid, done, busy} !== 3'b000 || round_idx !== 4'd0 || round_key !== fips[0]) begin
      failures++;
      $display("FAIL fips_hold: got v=%b d=%b b=%b idx=%0d key=%h, want idle holding round 0",
               rk_valid, done, busy, round_idx, round_key);
    end
  endtask

  task automatic test_zero_key();
    kick(ZERO_R10);
    for (int k = 0; k <= 20; k++) begin
      if (k == 18) begin
        checks++;
        if (rk_valid !== 1'b1 || round_idx !== 4'd1 || round_key !== ZERO_R1) begin
          failures++;
          $display("FAIL zero_r1: got v=%b idx=%0d key=%h, want v=1 idx=1 key=%h",
                   rk_valid, round_idx, round_key, ZERO_R1);
        end
      end
      if (k == 20) begin
        checks++;
        if (rk_valid !== 1'b1 || done !== 1'b1 || round_idx !== 4'd0 || round_key !== '0) begin
          failures++;
          $display("FAIL zero_r0: got v=%b d=%b idx=%0d key=%h, want v=1 d=1 idx=0 key=0",
                   rk_valid, done, round_idx, round_key);
        end
      end
      @(negedge clk);
    end
  endtask

  // Extra starts with a different key must change nothing.
  task automatic test_ignore_start();
    kick(fips[10]);
    for (int k = 0; k <= 20; k++) begin
      checks++;
      if (rk_valid !== (k % 2 == 0) || done !== (k == 20) || busy !== 1'b1 ||
          round_idx !== 4'(10 - k / 2) || round_key !== fips[10 - k / 2]) begin
        failures++;
        $display("FAIL ignore_start cyc %0d: got v=%b d=%b b=%b idx=%0d key=%h, want idx=%0d key=%h",
                 k, rk_valid, done, busy, round_idx, round_key, 10 - k / 2, fips[10 - k / 2]);
      end
      start  = (k == 3 || k == 7 || k == 15);
      key_in = ZERO_R10;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    kick(fips[10]);
    repeat (9) @(negedge clk);
    checks++;
    if (round_idx !== 4'd6 || round_key !== fips[6]) begin
      failures++;
      $display("FAIL reset_mid_pre: got idx=%0d key=%h, want idx=6 key=%h",
               round_idx, round_key, fips[6]);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rk_valid, done, busy} !== 3'b000 || round_key !== '0 || round_idx !== 4'd0) begin
      failures++;
      $display("FAIL reset_mid_async: got v=%b d=%b b=%b idx=%0d key=%h, want all zero",
               rk_valid, done, busy, round_idx, round_key);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      checks++;
      if ({rk_valid, done, busy} !== 3'b000) begin
        failures++;
        $display("FAIL reset_mid_quiet cyc %0d: got v=%b d=%b b=%b, want 0",
                 c, rk_valid, done, busy);
      end
    end
    kick(fips[10]);
    for (int k = 0; k <= 20; k++) begin
      if (k == 10 || k == 20) begin
        checks++;
        if (rk_valid !== 1'b1 || done !== (k == 20) || round_idx !== 4'(10 - k / 2) ||
            round_key !== fips[10 - k / 2]) begin
          failures++;
          $display("FAIL reset_mid_rerun cyc %0d: got v=%b d=%b idx=%0d key=%h, want idx=%0d key=%h",
                   k, rk_valid, done, round_idx, round_key, 10 - k / 2, fips[10 - k / 2]);
        end
      end
      @(negedge clk);
    end
  endtask

  // start held high: second run accepted at E21, dropped before E42.
  task automatic test_back_to_back();
    int pulses;
    int dones;
    pulses = 0;
    dones  = 0;
    key_in = fips[10];
    start  = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 48; k++) begin
      if (rk_valid === 1'b1) pulses++;
      if (done === 1'b1) dones++;
      checks++;
      if (busy !== (k <= 41)) begin
        failures++;
        $display("FAIL b2b_busy cyc %0d: got %b want %b", k, busy, (k <= 41));
      end
      if (k == 21) begin
        checks++;
        if (rk_valid !== 1'b1 || done !== 1'b0 || round_idx !== 4'd10 || round_key !== fips[10]) begin
          failures++;
          $display("FAIL b2b_second_r10: got v=%b d=%b idx=%0d key=%h, want v=1 d=0 idx=10",
                   rk_valid, done, round_idx, round_key);
        end
      end
      if (k == 41) begin
        checks++;
        if (done !== 1'b1 || round_key !== fips[0]) begin
          failures++;
          $display("FAIL b2b_second_done: got d=%b key=%h, want d=1 key=%h",
                   done, round_key, fips[0]);
        end
        start = 1'b0;
      end
      @(negedge clk);
    end
    checks++;
    if (pulses != 22 || dones != 2) begin
      failures++;
      $display("FAIL b2b_count: got pulses=%0d dones=%0d, want 22 and 2", pulses, dones);
    end
  endtask

  initial begin
    fips[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    test_reset();
    test_idle();
    test_fips();
    test_zero_key();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
